pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Sequencing controller for the 3-stage core (F, X = decode/execute, W = writeback).
- Consumes the decoded control of the instruction in X and the data-memory handshake.
- Generates stall, flush and forwarding selects, and the data-memory request.
- Holds the W-stage bookkeeping (rd, write enable) and runs a memory-access FSM with a timeout.

Parameters:
MEM_TIMEOUT, 64, max cycles a memory access may stay in REQ+WAIT before abort (>=2)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
x_valid  in  1  X holds a real instruction (not a bubble)
x_reg_write  in  1  X instruction writes rd
x_rd  in  5  X destination register
x_adr1  in  5  X source register 1
x_adr2  in  5  X source register 2
x_mem_access  in  1  X is load or store
x_is_load  in  1  X is load (wb_sel = 2'b01)
x_redirect  in  1  X is taken branch, JAL or JALR (never with x_mem_access)
dmem_gnt  in  1  memory accepted request
dmem_rvalid  in  1  load data valid
dmem_req  out  1  memory request
stall_f  out  1  hold PC and F/X register
stall_x  out  1  hold X-stage instruction and operands
flush_x  out  1  load bubble into F/X register next edge
fwd_a  out  1  select W result for operand A
fwd_b  out  1  select W result for operand B
w_valid  out  1  W holds a retiring instruction
w_we  out  1  register-file write strobe
w_rd  out  5  W destination register
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  count of cycles with stall_x = 1, saturating

Behaviour:
Reset (rst_n low, async):
- State goes to RUN.
- Timeout counter, w_valid, w_we, w_rd, mem_err and stall_cnt all clear to 0.

Combinational outputs:
- dmem_req, stall_f, stall_x, flush_x, fwd_a and fwd_b are combinational from state and inputs, so they read 0 during reset.

FSM states: RUN, REQ, WAIT.

RUN:
- If x_valid && x_mem_access: dmem_req = 1.
  - No dmem_gnt: stall, go to REQ.
  - dmem_gnt on a store: no stall; instruction advances.
  - dmem_gnt on a load with dmem_rvalid the same cycle: no stall; advance.
  - dmem_gnt on a load without dmem_rvalid: stall, go to WAIT.
- Otherwise: no stall.

REQ:
- dmem_req held at 1; address is stable (X is held).
- On dmem_gnt: store goes to RUN; load goes to RUN if dmem_rvalid, else to WAIT.
- Stall stays asserted in the gnt cycle unless the access completes.

WAIT:
- dmem_req = 0.
- On dmem_rvalid: stall deasserts that cycle, the load advances, go to RUN.

Stall and completion:
- stall = stall_f = stall_x, asserted in any cycle where the access does not complete.
- Completion cycle = the cycle stall drops; the datapath captures load data on that edge.

Timeout:
- Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
- When it reaches MEM_TIMEOUT-1: mem_err <= 1 (sticky until reset), go to RUN, stall drops.
- The aborted instruction retires as a bubble: w_we suppressed.
- A late dmem_rvalid or dmem_gnt arriving in RUN with no request outstanding is ignored.

Redirect:
- x_valid && x_redirect && !stall gives flush_x = 1 for one cycle, squashing the wrong-path fetch.
- The redirecting instruction itself advances normally.

W register (updates every edge):
- On advance: w_valid <= x_valid & !aborted; w_rd <= x_rd; w_we <= x_valid & x_reg_write & (x_rd != 0) & !aborted.
- On stall: w_valid <= 0 and w_we <= 0, inserting a bubble; w_rd is held.

Forwarding:
- fwd_a = w_we & (w_rd == x_adr1).
- fwd_b = w_we & (w_rd == x_adr2).
- x0 is never forwarded, since w_we already excludes rd = 0.

stall_cnt:
- Increments when stall_x = 1 and saturates at all-ones.

Simultaneous events:
- An asserted stall always overrides flush_x.

Decomposition:
- Shared package/defines: state encodings for RUN, REQ and WAIT; the WB_SEL_MEM constant (2'b01) used to derive x_is_load.
- One natural sub-module, pipe_mem_fsm: the RUN/REQ/WAIT FSM plus timeout counter, producing stall, dmem_req and abort.
- Forwarding, W register and stall_cnt stay in pipe_ctrl.

Test Plan:
1. ADD x5 retires, then the next instruction in X has adr1 = 5 and adr2 = 5 -> fwd_a = 1 and fwd_b = 1; with rd = 0 -> both 0 and w_we = 0.
2. Load with dmem_gnt delayed 2 cycles and dmem_rvalid 3 cycles after gnt -> stall_x high exactly 5 cycles, dmem_req high 3 cycles, stall_cnt = 5, then w_we = 1 for one cycle.
3. Store granted in the same cycle -> no stall, w_we = 0, w_valid = 1.
4. Taken branch in X with no stall -> flush_x = 1 for one cycle; the next X is a bubble and w_valid = 0 the following cycle.
5. Load with dmem_gnt never asserted, MEM_TIMEOUT = 8 -> stall for 8 cycles, mem_err = 1 and sticky, aborted load gives w_we = 0; a later stray dmem_rvalid is ignored.
6. rst_n dropped while in WAIT -> immediately dmem_req = 0, stall = 0, mem_err = 0; after release the state is RUN and a new load proceeds normally.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the 3-stage core sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_t;

  // Writeback-select code of a load; the decoder derives x_is_load from it.
  localparam logic [1:0] WB_SEL_MEM = 2'b01;

  function automatic logic is_load_sel(input logic [1:0] wb_sel);
    return wb_sel == WB_SEL_MEM;
  endfunction

endpackage

// File: rtl/pipe_mem_fsm.sv
// Data-memory access sequencer: RUN/REQ/WAIT with a bounded access time.
module pipe_mem_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x_valid,
  input  logic x_mem_access,
  input  logic x_is_load,
  input  logic dmem_gnt,
  input  logic dmem_rvalid,
  output logic dmem_req,
  output logic stall,
  output logic abort,
  output logic mem_err
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  mem_state_t    state;
  mem_state_t    state_next;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_last;
  logic          done;
  logic          req_comb;
  logic          stall_comb;
  logic          abort_comb;

  assign tmo_last = (tmo_cnt == TMO_LAST);

  // The request is dropped in the final REQ cycle so the abort decision
  // never depends combinationally on a grant answering that request.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    req_comb   = 1'b0;
    stall_comb = 1'b0;
    abort_comb = 1'b0;
    case (state)
      ST_RUN: begin
        if (x_valid && x_mem_access) begin
          req_comb   = 1'b1;
          done       = dmem_gnt && (!x_is_load || dmem_rvalid);
          stall_comb = !done;
          if (!dmem_gnt)  state_next = ST_REQ;
          else if (!done) state_next = ST_WAIT;
        end
      end
      ST_REQ: begin
        req_comb   = !tmo_last;
        done       = !tmo_last && dmem_gnt && (!x_is_load || dmem_rvalid);
        abort_comb = tmo_last;
        stall_comb = !done && !abort_comb;
        if (done || abort_comb) state_next = ST_RUN;
        else if (dmem_gnt)      state_next = ST_WAIT;
      end
      ST_WAIT: begin
        done       = dmem_rvalid;
        abort_comb = !done && tmo_last;
        stall_comb = !done && !abort_comb;
        if (done || abort_comb) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign dmem_req = rst_n & req_comb;
  assign stall    = rst_n & stall_comb;
  assign abort    = rst_n & abort_comb;

  // Counter is held at zero in RUN, so it starts from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_RUN) tmo_cnt <= '0;
      else                 tmo_cnt <= tmo_cnt + TW'(1);
      if (abort_comb) mem_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/forwarding control and W-stage bookkeeping for the F/X/W core.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_valid,
  input  logic             x_reg_write,
  input  logic [4:0]       x_rd,
  input  logic [4:0]       x_adr1,
  input  logic [4:0]       x_adr2,
  input  logic             x_mem_access,
  input  logic             x_is_load,
  input  logic             x_redirect,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  output logic             dmem_req,
  output logic             stall_f,
  output logic             stall_x,
  output logic             flush_x,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             w_valid,
  output logic             w_we,
  output logic [4:0]       w_rd,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  logic stall;
  logic abort;

  pipe_mem_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .x_valid     (x_valid),
    .x_mem_access(x_mem_access),
    .x_is_load   (x_is_load),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_req    (dmem_req),
    .stall       (stall),
    .abort       (abort),
    .mem_err     (mem_err)
  );

  assign stall_f = stall;
  assign stall_x = stall;
  assign flush_x = rst_n & x_valid & x_redirect & ~stall;

  // w_we already excludes rd = 0, so x0 can never be forwarded.
  assign fwd_a = w_we & (w_rd == x_adr1);
  assign fwd_b = w_we & (w_rd == x_adr2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_we    <= 1'b0;
      w_rd    <= '0;
    end else if (stall) begin
      w_valid <= 1'b0;
      w_we    <= 1'b0;
    end else begin
      w_valid <= x_valid & ~abort;
      w_rd    <= x_rd;
      w_we    <= x_valid & x_reg_write & (x_rd != 5'd0) & ~abort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: forwarding, load/store handshakes, redirect, timeout, reset.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        x_valid;
  logic        x_reg_write;
  logic [4:0]  x_rd;
  logic [4:0]  x_adr1;
  logic [4:0]  x_adr2;
  logic        x_mem_access;
  logic        x_is_load;
  logic        x_redirect;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic        dmem_req;
  logic        stall_f;
  logic        stall_x;
  logic        flush_x;
  logic        fwd_a;
  logic        fwd_b;
  logic        w_valid;
  logic        w_we;
  logic [4:0]  w_rd;
  logic        mem_err;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  int sc;
  int rc;

  pipe_ctrl #(
    .MEM_TIMEOUT(8),
    .CNT_W      (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x_valid     (x_valid),
    .x_reg_write (x_reg_write),
    .x_rd        (x_rd),
    .x_adr1      (x_adr1),
    .x_adr2      (x_adr2),
    .x_mem_access(x_mem_access),
    .x_is_load   (x_is_load),
    .x_redirect  (x_redirect),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_req    (dmem_req),
    .stall_f     (stall_f),
    .stall_x     (stall_x),
    .flush_x     (flush_x),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .w_valid     (w_valid),
    .w_we        (w_we),
    .w_rd        (w_rd),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    x_valid = 0; x_reg_write = 0; x_rd = 0; x_adr1 = 0; x_adr2 = 0;
    x_mem_access = 0; x_is_load = 0; x_redirect = 0;
    dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
    idle();
    x_valid = 1; x_reg_write = 1; x_rd = rd; x_adr1 = a1; x_adr2 = a2;
  endtask

  task automatic load(input logic [4:0] rd, input logic gnt, input logic rv);
    idle();
    x_valid = 1; x_reg_write = 1; x_rd = rd; x_adr1 = 5'd2;
    x_mem_access = 1; x_is_load = 1; dmem_gnt = gnt; dmem_rvalid = rv;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle();
    #3;
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_we", w_we, 0);
    chk("rst_w_rd", w_rd, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_stall_x", stall_x, 0);
    tick(); tick();
    rst_n = 1;

    // forwarding from a retired ADD x5, then an ADD x0
    alu(5'd5, 5'd1, 5'd2);
    #1 chk("t1_fwd_a_cold", fwd_a, 0);
    tick();
    alu(5'd6, 5'd5, 5'd5);
    #1;
    chk("t1_w_we_x5", w_we, 1);
    chk("t1_fwd_a", fwd_a, 1);
    chk("t1_fwd_b", fwd_b, 1);
    tick();
    alu(5'd0, 5'd5, 5'd6);
    #1;
    chk("t1_fwd_a_miss", fwd_a, 0);
    chk("t1_fwd_b_hit", fwd_b, 1);
    tick();
    alu(5'd3, 5'd0, 5'd0);
    #1;
    chk("t1_x0_w_valid", w_valid, 1);
    chk("t1_x0_w_we", w_we, 0);
    chk("t1_x0_fwd_a", fwd_a, 0);
    chk("t1_x0_fwd_b", fwd_b, 0);
    tick();

    // load: gnt two cycles late, rvalid three cycles after gnt
    sc = 0; rc = 0;
    for (int c = 0; c < 6; c++) begin
      load(5'd7, c == 2, c == 5);
      #1;
      if (stall_x) sc++;
      if (dmem_req) rc++;
      chk($sformatf("t2_stall_f_c%0d", c), stall_f, (c < 5) ? 1 : 0);
      if (c == 1) chk("t2_bubble_w_valid", w_valid, 0);
      tick();
    end
    chk("t2_stall_cycles", sc, 5);
    chk("t2_req_cycles", rc, 3);
    chk("t2_stall_cnt", stall_cnt, 5);
    chk("t2_w_we", w_we, 1);
    chk("t2_w_rd", w_rd, 7);
    idle();
    tick();
    chk("t2_w_we_once", w_we, 0);

    // store granted in the same cycle
    idle();
    x_valid = 1; x_mem_access = 1; x_adr1 = 5'd4; dmem_gnt = 1;
    #1;
    chk("t3_stall_x", stall_x, 0);
    chk("t3_dmem_req", dmem_req, 1);
    tick();
    chk("t3_w_valid", w_valid, 1);
    chk("t3_w_we", w_we, 0);

    // taken JAL x1: flush for one cycle, then a bubble in X
    idle();
    x_valid = 1; x_redirect = 1; x_reg_write = 1; x_rd = 5'd1;
    #1;
    chk("t4_flush_x", flush_x, 1);
    chk("t4_stall_x", stall_x, 0);
    tick();
    chk("t4_jal_w_we", w_we, 1);
    idle();
    #1 chk("t4_flush_once", flush_x, 0);
    tick();
    chk("t4_bubble_w_valid", w_valid, 0);

    // load whose grant never comes: aborted after MEM_TIMEOUT
    sc = 0;
    for (int c = 0; c < 9; c++) begin
      load(5'd9, 0, 0);
      #1;
      if (stall_x) sc++;
      tick();
    end
    chk("t5_stall_cycles", sc, 8);
    chk("t5_mem_err", mem_err, 1);
    chk("t5_abort_w_we", w_we, 0);
    chk("t5_abort_w_valid", w_valid, 0);
    chk("t5_stall_cnt", stall_cnt, 13);
    idle();
    dmem_rvalid = 1; dmem_gnt = 1;
    #1;
    chk("t5_stray_stall", stall_x, 0);
    chk("t5_stray_req", dmem_req, 0);
    tick();
    chk("t5_mem_err_sticky", mem_err, 1);
    chk("t5_stray_w_valid", w_valid, 0);
    load(5'd12, 1, 1);
    #1 chk("t5_next_load_stall", stall_x, 0);
    tick();
    chk("t5_next_load_w_we", w_we, 1);
    chk("t5_next_load_w_rd", w_rd, 12);

    // reset while waiting for load data
    load(5'd10, 1, 0);
    #1 chk("t6_enter_wait_stall", stall_x, 1);
    tick();
    dmem_gnt = 0;
    #1;
    chk("t6_wait_stall", stall_x, 1);
    chk("t6_wait_req", dmem_req, 0);
    rst_n = 0;
    #1;
    chk("t6_rst_req", dmem_req, 0);
    chk("t6_rst_stall", stall_x, 0);
    chk("t6_rst_mem_err", mem_err, 0);
    chk("t6_rst_stall_cnt", stall_cnt, 0);
    tick();
    rst_n = 1;
    load(5'd11, 1, 1);
    #1;
    chk("t6_new_load_stall", stall_x, 0);
    chk("t6_new_load_req", dmem_req, 1);
    tick();
    chk("t6_new_load_w_we", w_we, 1);
    chk("t6_new_load_w_rd", w_rd, 11);
    chk("t6_stall_cnt", stall_cnt, 0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
